// File: rtl/ili9341_pkg.sv
// Shared opcodes, decoder states and panel geometry defaults for the ILI9341 command decoder.
package ili9341_pkg;

    localparam int PANEL_WIDTH  = 240;
    localparam int PANEL_HEIGHT = 320;
    localparam int WIN_START_RESET = 0;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COL_ARGS,
        ST_ROW_ARGS,
        ST_PIX_HI,
        ST_PIX_LO,
        ST_SKIP
    } state_t;

    // Clamp a requested window end coordinate to the last valid panel index.
    function automatic logic [15:0] clamp_end(input logic [15:0] req, input logic [15:0] max_idx);
        return (req > max_idx) ? max_idx : req;
    endfunction

endpackage

// File: rtl/ili9341_cmd_decoder_if.sv
// Byte-stream input and addressed-pixel output bundle of the ILI9341 command decoder.
interface ili9341_cmd_decoder_if #(
    parameter int X_BITS = 9,
    parameter int Y_BITS = 9
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              dc_in;
    logic [X_BITS-1:0] px_x;
    logic [Y_BITS-1:0] px_y;
    logic [15:0]       px_data;
    logic              px_valid;
    logic              frame_done;
    logic              display_on;
    logic              bad_cmd;

    modport master (
        output byte_in, byte_valid, dc_in,
        input  px_x, px_y, px_data, px_valid, frame_done, display_on, bad_cmd
    );

    modport slave (
        input  byte_in, byte_valid, dc_in,
        output px_x, px_y, px_data, px_valid, frame_done, display_on, bad_cmd
    );
endinterface

// File: rtl/ili9341_window_cursor.sv
// Address window registers with clamp/reject commit, plus the write cursor that wraps inside the window.
module ili9341_window_cursor
    import ili9341_pkg::*;
#(
    parameter int WIDTH  = PANEL_WIDTH,
    parameter int HEIGHT = PANEL_HEIGHT,
    parameter int X_BITS = 9,
    parameter int Y_BITS = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_reset,
    input  logic              commit_col,
    input  logic              commit_row,
    input  logic [15:0]       arg_start,
    input  logic [15:0]       arg_end,
    input  logic              cursor_load,
    input  logic              cursor_step,
    output logic [X_BITS-1:0] cur_x,
    output logic [Y_BITS-1:0] cur_y,
    output logic              at_last
);

    localparam logic [15:0] X_MAX = 16'(WIDTH - 1);
    localparam logic [15:0] Y_MAX = 16'(HEIGHT - 1);

    logic [X_BITS-1:0] xs, xe;
    logic [Y_BITS-1:0] ys, ye;
    logic [15:0]       col_end, row_end;
    logic              col_ok, row_ok;
    logic              x_wrap, y_wrap;

    // A start beyond the clamped end would describe an empty window, so it is refused.
    assign col_end = clamp_end(arg_end, X_MAX);
    assign row_end = clamp_end(arg_end, Y_MAX);
    assign col_ok  = (arg_start <= col_end);
    assign row_ok  = (arg_start <= row_end);

    assign x_wrap  = (cur_x >= xe);
    assign y_wrap  = (cur_y >= ye);
    assign at_last = x_wrap && y_wrap;

    always_ff @(posedge clk) begin
        if (rst || sw_reset) begin
            xs    <= X_BITS'(WIN_START_RESET);
            xe    <= X_BITS'(WIDTH - 1);
            ys    <= Y_BITS'(WIN_START_RESET);
            ye    <= Y_BITS'(HEIGHT - 1);
            cur_x <= '0;
            cur_y <= '0;
        end else begin
            if (commit_col && col_ok) begin
                xs <= arg_start[X_BITS-1:0];
                xe <= col_end[X_BITS-1:0];
            end
            if (commit_row && row_ok) begin
                ys <= arg_start[Y_BITS-1:0];
                ye <= row_end[Y_BITS-1:0];
            end
            if (cursor_load) begin
                cur_x <= xs;
                cur_y <= ys;
            end else if (cursor_step) begin
                if (!x_wrap) begin
                    cur_x <= cur_x + X_BITS'(1);
                end else begin
                    cur_x <= xs;
                    cur_y <= y_wrap ? ys : cur_y + Y_BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ili9341_cmd_decoder.sv
// ILI9341 command decoder: turns the SPI byte stream and D/C line into windowed RGB565 pixel writes.
module ili9341_cmd_decoder
    import ili9341_pkg::*;
#(
    parameter int WIDTH  = PANEL_WIDTH,
    parameter int HEIGHT = PANEL_HEIGHT,
    parameter int X_BITS = 9,
    parameter int Y_BITS = 9
) (
    input logic                clk,
    input logic                rst,
    ili9341_cmd_decoder_if.slave bus
);

    state_t            state, state_nxt;
    logic [1:0]        arg_cnt;
    logic [23:0]       arg_buf;
    logic [7:0]        pix_hi;
    logic              is_cmd, is_data;
    logic              bad_nxt;
    logic              commit_col, commit_row;
    logic              cursor_load, pix_emit, sw_reset;
    logic [X_BITS-1:0] cur_x;
    logic [Y_BITS-1:0] cur_y;
    logic              at_last;

    assign is_cmd      = bus.byte_valid && !bus.dc_in;
    assign is_data     = bus.byte_valid && bus.dc_in;
    assign commit_col  = is_data && (state == ST_COL_ARGS) && (arg_cnt == 2'd3);
    assign commit_row  = is_data && (state == ST_ROW_ARGS) && (arg_cnt == 2'd3);
    assign cursor_load = is_cmd && (bus.byte_in == CMD_RAMWR);
    assign sw_reset    = is_cmd && (bus.byte_in == CMD_SWRESET);
    assign pix_emit    = is_data && (state == ST_PIX_LO);

    ili9341_window_cursor #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .X_BITS(X_BITS),
        .Y_BITS(Y_BITS)
    ) u_window_cursor (
        .clk        (clk),
        .rst        (rst),
        .sw_reset   (sw_reset),
        .commit_col (commit_col),
        .commit_row (commit_row),
        .arg_start  (arg_buf[23:8]),
        .arg_end    ({arg_buf[7:0], bus.byte_in}),
        .cursor_load(cursor_load),
        .cursor_step(pix_emit),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .at_last    (at_last)
    );

    // Any command byte overrides whatever the current state was collecting.
    always_comb begin
        state_nxt = state;
        bad_nxt   = 1'b0;
        if (is_cmd) begin
            case (bus.byte_in)
                CMD_CASET:   state_nxt = ST_COL_ARGS;
                CMD_PASET:   state_nxt = ST_ROW_ARGS;
                CMD_RAMWR:   state_nxt = ST_PIX_HI;
                CMD_NOP,
                CMD_SWRESET,
                CMD_DISPON,
                CMD_DISPOFF: state_nxt = ST_IDLE;
                default: begin
                    state_nxt = ST_SKIP;
                    bad_nxt   = 1'b1;
                end
            endcase
        end else if (is_data) begin
            case (state)
                ST_COL_ARGS,
                ST_ROW_ARGS: if (arg_cnt == 2'd3) state_nxt = ST_IDLE;
                ST_PIX_HI:   state_nxt = ST_PIX_LO;
                ST_PIX_LO:   state_nxt = ST_PIX_HI;
                default:     state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            arg_cnt        <= '0;
            arg_buf        <= '0;
            pix_hi         <= '0;
            bus.px_x       <= '0;
            bus.px_y       <= '0;
            bus.px_data    <= '0;
            bus.px_valid   <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.display_on <= 1'b0;
            bus.bad_cmd    <= 1'b0;
        end else begin
            state          <= state_nxt;
            bus.bad_cmd    <= bad_nxt;
            bus.px_valid   <= pix_emit;
            bus.frame_done <= pix_emit && at_last;
            if (is_cmd) begin
                arg_cnt <= '0;
                if (bus.byte_in == CMD_DISPON)
                    bus.display_on <= 1'b1;
                else if (bus.byte_in == CMD_DISPOFF || bus.byte_in == CMD_SWRESET)
                    bus.display_on <= 1'b0;
            end else if (is_data && (state == ST_COL_ARGS || state == ST_ROW_ARGS)) begin
                arg_buf <= {arg_buf[15:0], bus.byte_in};
                arg_cnt <= arg_cnt + 2'd1;
            end
            if (is_data && state == ST_PIX_HI)
                pix_hi <= bus.byte_in;
            if (pix_emit) begin
                bus.px_data <= {pix_hi, bus.byte_in};
                bus.px_x    <= cur_x;
                bus.px_y    <= cur_y;
            end
        end
    end

endmodule

// File: tb/tb_ili9341_cmd_decoder.sv
// Directed plus randomized bench for ili9341_cmd_decoder against a command/argument-queue reference model.
module tb_ili9341_cmd_decoder;

    localparam int WIDTH  = 240;
    localparam int HEIGHT = 320;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ili9341_cmd_decoder_if #(.X_BITS(9), .Y_BITS(9)) bus ();

    ili9341_cmd_decoder #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .X_BITS(9),
        .Y_BITS(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: the last command seen plus the data bytes gathered since then.
    int          m_xs, m_xe, m_ys, m_ye, m_cx, m_cy;
    bit          m_disp;
    int          m_cmd;
    int          m_q[$];
    int          e_px_x, e_px_y, e_px_data;
    bit          e_valid, e_fd, e_bad;

    task automatic modelWindowReset();
        m_xs = 0; m_xe = WIDTH - 1; m_ys = 0; m_ye = HEIGHT - 1;
        m_cx = 0; m_cy = 0;
    endtask

    task automatic modelReset();
        modelWindowReset();
        m_disp = 0; m_cmd = -1; m_q.delete();
        e_px_x = 0; e_px_y = 0; e_px_data = 0;
        e_valid = 0; e_fd = 0; e_bad = 0;
    endtask

    task automatic modelStep(input bit v, input bit dc, input int b);
        int s, e, lim;
        e_valid = 0; e_fd = 0; e_bad = 0;
        if (!v) return;
        if (!dc) begin
            m_q.delete();
            m_cmd = -1;
            case (b)
                'h2A, 'h2B: m_cmd = b;
                'h2C: begin m_cmd = b; m_cx = m_xs; m_cy = m_ys; end
                'h29: m_disp = 1;
                'h28: m_disp = 0;
                'h01: begin modelWindowReset(); m_disp = 0; end
                'h00: ;
                default: e_bad = 1;
            endcase
        end else if (m_cmd == 'h2A || m_cmd == 'h2B) begin
            m_q.push_back(b);
            if (m_q.size() == 4) begin
                s   = m_q[0] * 256 + m_q[1];
                e   = m_q[2] * 256 + m_q[3];
                lim = (m_cmd == 'h2A) ? WIDTH - 1 : HEIGHT - 1;
                if (e > lim) e = lim;
                if (s <= e) begin
                    if (m_cmd == 'h2A) begin m_xs = s; m_xe = e; end
                    else begin m_ys = s; m_ye = e; end
                end
                m_cmd = -1;
                m_q.delete();
            end
        end else if (m_cmd == 'h2C) begin
            m_q.push_back(b);
            if (m_q.size() == 2) begin
                e_valid   = 1;
                e_px_x    = m_cx;
                e_px_y    = m_cy;
                e_px_data = m_q[0] * 256 + m_q[1];
                m_q.delete();
                if (m_cx < m_xe) m_cx++;
                else begin
                    m_cx = m_xs;
                    if (m_cy < m_ye) m_cy++;
                    else begin m_cy = m_ys; e_fd = 1; end
                end
            end
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkVal("px_valid",   32'(bus.px_valid),   32'(e_valid));
        checkVal("frame_done", 32'(bus.frame_done), 32'(e_fd));
        checkVal("bad_cmd",    32'(bus.bad_cmd),    32'(e_bad));
        checkVal("display_on", 32'(bus.display_on), 32'(m_disp));
        checkVal("px_x",       32'(bus.px_x),       32'(e_px_x));
        checkVal("px_y",       32'(bus.px_y),       32'(e_px_y));
        checkVal("px_data",    32'(bus.px_data),    32'(e_px_data));
    endtask

    // Drives one cycle of inputs, lets the DUT clock them in, then advances the model and compares.
    task automatic applyStimulus(input logic r, input logic v, input logic dc, input logic [7:0] b);
        rst            = r;
        bus.byte_valid = v;
        bus.dc_in      = dc;
        bus.byte_in    = b;
        @(posedge clk);
        #1;
        if (r) modelReset();
        else   modelStep(v, dc, int'(b));
        checkOutput();
    endtask

    task automatic sendCmd(input logic [7:0] b);
        applyStimulus(1'b0, 1'b1, 1'b0, b);
    endtask

    task automatic sendData(input logic [7:0] b);
        applyStimulus(1'b0, 1'b1, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic sendWindow(input logic [7:0] cmd, input int s, input int e, input int nargs);
        logic [15:0] sv, ev;
        logic [7:0]  args [4];
        sv = 16'(s);
        ev = 16'(e);
        args[0] = sv[15:8]; args[1] = sv[7:0]; args[2] = ev[15:8]; args[3] = ev[7:0];
        sendCmd(cmd);
        for (int i = 0; i < nargs; i++) begin
            sendData(args[i]);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    initial begin
        int op, s, e, n;
        clk    = 1'b0;
        checks = 0;
        errors = 0;
        modelReset();

        $display("[TB] reset and first pixels");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h29);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        idle(2);
        sendCmd(8'h2C);
        sendData(8'hF8);
        sendData(8'h00);
        checkVal("plan_px0", {bus.px_valid, 6'd0, bus.px_x, bus.px_y, 7'd0}, {1'b1, 6'd0, 9'd0, 9'd0, 7'd0});
        checkVal("plan_px0_data", 32'(bus.px_data), 32'hF800);
        sendData(8'h07);
        sendData(8'hE0);
        checkVal("plan_px1_x", 32'(bus.px_x), 32'd1);
        checkVal("plan_px1_data", 32'(bus.px_data), 32'h07E0);

        $display("[TB] small window wrap");
        sendWindow(8'h2A, 10, 11, 4);
        sendWindow(8'h2B, 20, 21, 4);
        sendCmd(8'h2C);
        for (int p = 0; p < 5; p++) begin
            sendData(8'(p));
            sendData(8'h5A);
            if (p == 3) checkVal("plan_frame_done", 32'(bus.frame_done), 32'd1);
        end
        checkVal("plan_wrap_xy", {bus.px_x, bus.px_y}, {9'd10, 9'd20});

        $display("[TB] clamp and reject");
        sendWindow(8'h2A, 5, 16'h01FF, 4);
        sendWindow(8'h2A, 16'h20, 16'h10, 4);
        sendCmd(8'h2C);
        sendData(8'h12);
        sendData(8'h34);
        checkVal("plan_clamp_x", 32'(bus.px_x), 32'd5);

        $display("[TB] aborted pixel and stray data");
        sendCmd(8'h2C);
        sendData(8'hAB);
        sendCmd(8'h29);
        checkVal("plan_dispon", {bus.px_valid, bus.display_on}, 2'b01);
        sendData(8'hCD);
        sendData(8'hEF);

        $display("[TB] bad command and software reset");
        sendCmd(8'h36);
        checkVal("plan_bad_cmd", 32'(bus.bad_cmd), 32'd1);
        sendData(8'h48);
        sendCmd(8'h01);
        sendCmd(8'h2C);
        sendData(8'h00);
        sendData(8'h01);
        checkVal("plan_swreset_xy", {bus.px_x, bus.px_y, bus.display_on}, {9'd0, 9'd0, 1'b0});

        $display("[TB] back-to-back bytes and mid-stream reset");
        sendCmd(8'h2C);
        for (int k = 0; k < 8; k++) sendData(8'(8'h80 + k));
        sendData(8'h11);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h22);
        idle(1);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 400; t++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: begin
                    s = $urandom_range(0, 15);
                    e = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 400) : s + $urandom_range(0, 3);
                    n = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : 4;
                    sendWindow((op == 0) ? 8'h2A : 8'h2B, s, e, n);
                end
                2: begin
                    sendCmd(8'h2C);
                    n = $urandom_range(0, 14);
                    for (int k = 0; k < n; k++) begin
                        sendData(8'($urandom));
                        if ($urandom_range(0, 4) == 0) idle(1);
                    end
                end
                3: begin
                    case ($urandom_range(0, 5))
                        0: sendCmd(8'h29);
                        1: sendCmd(8'h28);
                        2: sendCmd(8'h00);
                        3: sendCmd(8'h01);
                        default: sendCmd(8'($urandom_range(8'h30, 8'hFF)));
                    endcase
                end
                4: begin
                    n = $urandom_range(1, 4);
                    for (int k = 0; k < n; k++) sendData(8'($urandom));
                end
                default: begin
                    if ($urandom_range(0, 15) == 0) applyStimulus(1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
                    else idle($urandom_range(1, 3));
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ili9341_cmd_decoder.md
Name: ili9341_cmd_decoder

Overview:
Sequences the byte stream from the SPI deserializer (data byte plus one-clk data_ready pulse) together with the panel D/C line.
Decodes the ILI9341 command subset CASET/PASET/RAMWR/DISPON/DISPOFF/SWRESET and emits addressed RGB565 pixel writes toward the framebuffer.
It is the controller between the SPI front end and the pixel store.

Parameters:
WIDTH, 240, panel columns
HEIGHT, 320, panel rows
X_BITS, 9, width of column coordinate (must hold WIDTH-1)
Y_BITS, 9, width of row coordinate (must hold HEIGHT-1)

Ports:
clk  input  1  system clock, faster than SPI sck
rst  input  1  synchronous, active-high reset
byte_in  input  8  received byte, valid when byte_valid=1
byte_valid  input  1  one-clk strobe per received byte; back-to-back strobes allowed
dc_in  input  1  D/C level sampled with byte_valid: 0=command, 1=data
px_x  output  X_BITS  pixel column
px_y  output  Y_BITS  pixel row
px_data  output  16  RGB565 pixel, first byte in bits 15:8
px_valid  output  1  one-clk write strobe
frame_done  output  1  one-clk pulse coincident with px_valid of the last pixel in the window
display_on  output  1  level; set by DISPON, cleared by DISPOFF/SWRESET
bad_cmd  output  1  one-clk pulse on an unsupported command byte

Behaviour:
- Reset values:
  - px_x=0, px_y=0, px_data=0, px_valid=0, frame_done=0, display_on=0, bad_cmd=0.
  - Window xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1; state IDLE.
- All inputs are ignored while byte_valid=0. rst has priority over a same-cycle byte_valid.
- A command byte (dc_in=0) always aborts the current state and is decoded immediately:
  - 0x2A CASET -> COL_ARGS, arg count=0.
  - 0x2B PASET -> ROW_ARGS, arg count=0.
  - 0x2C RAMWR -> PIX_HI; cursor x=xs, y=ys.
  - 0x29 DISPON -> display_on=1, then IDLE.
  - 0x28 DISPOFF -> display_on=0, then IDLE.
  - 0x01 SWRESET -> window, cursor and display_on return to reset values; IDLE.
  - 0x00 NOP -> IDLE.
  - Any other value -> bad_cmd pulse next cycle; state SKIP (discards data bytes until the next command).
- Data bytes (dc_in=1):
  - IDLE/SKIP: discarded.
  - COL_ARGS / ROW_ARGS: collect 4 bytes (start hi, start lo, end hi, end lo) into 16-bit start/end.
    - On the 4th byte, end is clamped to WIDTH-1 (or HEIGHT-1 for rows).
    - If start > clamped end, the update is rejected and the old window is kept; otherwise the window is committed.
    - Either way, state -> IDLE.
    - A command arriving before the 4th byte leaves the window unchanged.
  - PIX_HI: latch byte as px_data[15:8] -> PIX_LO.
  - PIX_LO: next cycle px_data={hi,byte}, px_x/px_y=cursor, px_valid=1 (latency 1 clk from the lo byte strobe); state -> PIX_HI.
- Cursor advance per emitted pixel:
  - x<xe: x+1.
  - x==xe: x=xs, then y+1; if y==ye, y=ys and frame_done=1 with that pixel.
  - Writing continues indefinitely, wrapping within the window.
- A command arriving in PIX_LO drops the half pixel; no px_valid is generated.
- px_valid, frame_done and bad_cmd are single-cycle pulses. px_x, px_y and px_data hold their values between strobes.
- Window registers change only on CASET/PASET commit or SWRESET, never during RAMWR.

Decomposition:
- Package ili9341_pkg:
  - opcode constants (CMD_NOP, CMD_SWRESET, CMD_DISPOFF, CMD_DISPON, CMD_CASET, CMD_PASET, CMD_RAMWR)
  - state enum/localparams
  - reset defaults for the window
- One natural sub-module, ili9341_window_cursor: holds xs/xe/ys/ye, handles commit with clamp/reject, and does the cursor increment/wrap with the frame_done flag.
- The top level holds the FSM and argument collection.

Test Plan:
- After reset, send RAMWR then data F8,00,07,E0 -> px_valid twice: (0,0,F800) then (1,0,07E0); frame_done=0.
- CASET 00,0A,00,0B; PASET 00,14,00,15; RAMWR plus 4 pixels -> coords (10,20),(11,20),(10,21),(11,21); frame_done on the 4th; a 5th pixel lands at (10,20).
- CASET 00,05,01,FF -> end clamped to 239; CASET 00,20,00,10 -> rejected, window stays 5..239; verify with a RAMWR whose first pixel lands at x=5.
- RAMWR, data AB, then command 0x29 -> no px_valid, display_on=1; a following data byte is discarded (IDLE).
- Command 0x36 then data 48 -> bad_cmd pulse, no state change visible, no px_valid; then SWRESET -> window 0..239/0..319, display_on=0.
- Back-to-back byte_valid every clk for 8 data bytes after RAMWR -> 4 px_valid strobes each 1 clk after its lo byte; rst asserted mid-stream -> all outputs at reset values the next cycle.
